qspi_mgmt_host: RTL and testbench
=================================

QSPI_MGMT_HOST -- requirements
Module: qspi_mgmt_host

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCK period; it must be even and at least 2.
REQ-002 The block SHALL have parameter DUMMY_CYCLES, default 4, giving SCK cycles of bus turnaround before read data.
REQ-003 The block SHALL have parameter CS_GAP, default 4, giving the minimum number of clk cycles cs_n stays high between transactions.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-006 The block SHALL have port rd_en, input, 1, a one-cycle register-read request.
REQ-007 The block SHALL have port wr_en, input, 1, a one-cycle register-write request.
REQ-008 The block SHALL have port addr, input, 16, the register address, sampled on request.
REQ-009 The block SHALL have port wr_data, input, 8, the write byte, sampled on request.
REQ-010 The block SHALL have port busy, output, 1, high while a transaction or gap is in progress.
REQ-011 The block SHALL have port rd_valid, output, 1, a one-cycle read-complete strobe.
REQ-012 The block SHALL have port rd_data, output, 8, the read byte, held until the next read completes.
REQ-013 The block SHALL have port qspi_sck, output, 1, the SPI clock, which idles low (mode 0).
REQ-014 The block SHALL have port qspi_cs_n, output, 1, an active-low chip select.
REQ-015 The block SHALL have port qspi_dq_out, output, 4, the data driven to the IO buffer.
REQ-016 The block SHALL have port qspi_dq_oe, output, 1, the output enable for the bidirectional buffer.
REQ-017 The block SHALL have port qspi_dq_in, input, 4, the data received from the IO buffer.

Function
REQ-018 The block SHALL run the whole frame in x4 mode, MSB nibble first: an 8-bit opcode (2 SCK), then a 16-bit address (4 SCK), then the data phase.
REQ-019 The opcode SHALL be 0x02 for a write and 0x0B for a read.
REQ-020 Write data phase: wr_data is sent as 2 nibbles, high nibble first, with qspi_dq_oe=1.
REQ-021 Read data phase: DUMMY_CYCLES SCK cycles with qspi_dq_oe=0, then 2 SCK cycles of sampling qspi_dq_in, high nibble first.
REQ-022 SCK timing: SCK is low for CLK_DIV/2 clk cycles, then high for CLK_DIV/2.
REQ-023 qspi_dq_out and qspi_dq_oe change only on the clk edge where SCK falls, or at cs_n assertion for the first nibble.
REQ-024 qspi_dq_in is sampled on the clk edge where SCK rises.
REQ-025 qspi_dq_oe drops at the SCK falling edge that ends the last address nibble, i.e. one half-period before the first dummy rising edge.
REQ-026 The states SHALL be IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, END and GAP.
- IDLE -> CMD on an accepted request.
- CMD -> ADDR after 2 SCK.
- ADDR -> WDATA for a write, or ADDR -> DUMMY for a read, after 4 SCK.
- DUMMY -> RDATA after DUMMY_CYCLES SCK.
- WDATA or RDATA -> END after 2 SCK.
- END -> GAP.
- GAP -> IDLE after CS_GAP clk cycles.
REQ-027 A request SHALL be accepted only in IDLE; in that cycle addr and wr_data are latched and busy rises on the next cycle.
REQ-028 A request while busy=1 SHALL be silently dropped.
REQ-029 If rd_en and wr_en are asserted in the same cycle, the write SHALL be performed and the read dropped.
REQ-030 qspi_cs_n SHALL fall one clk cycle after acceptance.
REQ-031 qspi_cs_n SHALL rise in END, at least CLK_DIV/2 clk cycles after the last SCK falling edge, with SCK low.
REQ-032 For a read, rd_valid SHALL pulse for 1 clk in the END cycle and rd_data SHALL update in that same cycle.
REQ-033 busy SHALL stay high through GAP and drop on the cycle the block enters IDLE.
REQ-034 Total SCK cycles: a write is 8 and a read is 8+DUMMY_CYCLES.
REQ-035 SCK SHALL never toggle while cs_n=1.

Reset
REQ-036 While rst_n=0, on each clk edge the block SHALL set: state=IDLE, qspi_cs_n=1, qspi_sck=0, qspi_dq_oe=0, qspi_dq_out=0, busy=0, rd_valid=0, rd_data=0x00.
REQ-037 A reset asserted mid-transaction SHALL abort the transaction, with no rd_valid pulse, and cs_n high on the next clk edge.
REQ-038 After reset is released, the first request SHALL be accepted in the same cycle, with no CS_GAP applied.

Verification
REQ-039 Write: wr_en, addr=0x1234, wr_data=0xA5, CLK_DIV=4 -> DQ nibbles 0,2,1,2,3,4,A,5 and oe=1 throughout; 8 SCK; cs_n low for 32±2 clk.
REQ-040 Read: rd_en, addr=0x00FF, model drives 0x3C after 4 dummy cycles -> nibbles 0,B,0,0,F,F; oe=0 for 6 SCK; rd_valid pulses once with rd_data=0x3C.
REQ-041 Collision: rd_en and wr_en together (addr=0x0010, wr_data=0x55) -> write frame only (opcode 0x02), no rd_valid.
REQ-042 Back-to-back: a second wr_en issued while busy -> dropped; a request in the first IDLE cycle is accepted, and the cs_n high time is ≥CS_GAP.
REQ-043 Reset abort: rst_n=0 during the read DUMMY phase -> next edge gives cs_n=1, sck=0, oe=0, busy=0, no rd_valid; a subsequent read completes correctly.
REQ-044 CLK_DIV=2: a read at addr=0xFFFF returning 0xFF -> SCK period of 2 clk, rd_data=0xFF, 12 SCK pulses.

Source files
------------

// File: rtl/qspi_mgmt_host.sv
// QSPI management host: issues single-byte register reads and writes as x4 frames
// (opcode, 16-bit address, dummy turnaround for reads, one data byte).
module qspi_mgmt_host #(
  parameter int CLK_DIV      = 4,
  parameter int DUMMY_CYCLES = 4,
  parameter int CS_GAP       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        qspi_sck,
  output logic        qspi_cs_n,
  output logic [3:0]  qspi_dq_out,
  output logic        qspi_dq_oe,
  input  logic [3:0]  qspi_dq_in
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h0B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, END, GAP} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       cnt;
  logic             tail;
  logic             is_write;
  logic [31:0]      tx;
  logic [7:0]       rx;
  logic [GAP_W-1:0] gap_cnt;
  logic             active, rise, fall, tail_done, req;
  logic [7:0]       op;

  assign busy = (state != IDLE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    active     = state inside {CMD, ADDR, DUMMY, RDATA, WDATA};
    rise       = active && !tail && (div_cnt == DIV_W'(HALF - 1));
    fall       = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    tail_done  = active && tail && (div_cnt == DIV_W'(HALF - 1));
    req        = rd_en | wr_en;
    op         = wr_en ? OP_WRITE : OP_READ;
    state_next = state;
    case (state)
      IDLE:         if (req) state_next = CMD;
      CMD:          if (fall && cnt == 8'd1) state_next = ADDR;
      ADDR:         if (fall && cnt == 8'd3) state_next = is_write ? WDATA : DUMMY;
      DUMMY:        if (fall && cnt == 8'(DUMMY_CYCLES - 1)) state_next = RDATA;
      RDATA, WDATA: if (tail_done) state_next = END;
      END:          state_next = GAP;
      GAP:          if (gap_cnt == GAP_W'(CS_GAP - 1)) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      cnt         <= '0;
      tail        <= 1'b0;
      is_write    <= 1'b0;
      tx          <= '0;
      rx          <= '0;
      gap_cnt     <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      qspi_sck    <= 1'b0;
      qspi_cs_n   <= 1'b1;
      qspi_dq_out <= '0;
      qspi_dq_oe  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (active) div_cnt <= fall ? '0 : div_cnt + 1'b1;
      if (rise) begin
        qspi_sck <= 1'b1;
        rx       <= {rx[3:0], qspi_dq_in};
      end
      if (fall) begin
        qspi_sck <= 1'b0;
        cnt      <= (state_next != state) ? '0 : cnt + 1'b1;
      end
      case (state)
        IDLE: if (req) begin
          // a write wins a collision because the opcode and direction follow wr_en
          is_write    <= wr_en;
          tx          <= {op[3:0], addr, wr_data, 4'h0};
          qspi_dq_out <= op[7:4];
          qspi_dq_oe  <= 1'b1;
          qspi_cs_n   <= 1'b0;
          div_cnt     <= '0;
          cnt         <= '0;
          tail        <= 1'b0;
        end
        CMD, ADDR: if (fall) begin
          if (state_next == DUMMY) begin
            qspi_dq_oe  <= 1'b0;
            qspi_dq_out <= '0;
          end else begin
            qspi_dq_out <= tx[31:28];
            tx          <= {tx[27:0], 4'h0};
          end
        end
        WDATA: if (fall) begin
          if (cnt == 8'd1) begin
            qspi_dq_oe  <= 1'b0;
            qspi_dq_out <= '0;
            tail        <= 1'b1;
          end else begin
            qspi_dq_out <= tx[31:28];
            tx          <= {tx[27:0], 4'h0};
          end
        end
        RDATA: if (fall && cnt == 8'd1) tail <= 1'b1;
        END:   gap_cnt <= '0;
        GAP:   gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
      // the tail keeps cs_n low for half an SCK period after the last falling edge
      if (tail_done) begin
        qspi_cs_n <= 1'b1;
        tail      <= 1'b0;
        if (!is_write) begin
          rd_valid <= 1'b1;
          rd_data  <= rx;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_mgmt_host.sv
// Bench for qspi_mgmt_host: frame scoreboard on a CLK_DIV=4 instance plus a
// short read on a CLK_DIV=2 instance.
module tb_qspi_mgmt_host;

  localparam int DUMMY  = 4;
  localparam int CS_GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rd_en, wr_en;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        busy, rd_valid, sck, cs_n, dq_oe;
  logic [7:0]  rd_data;
  logic [3:0]  dq_out, dq_in;

  logic        b_rd_en, b_wr_en;
  logic [15:0] b_addr;
  logic [7:0]  b_wr_data;
  logic        b_busy, b_rd_valid, b_sck, b_cs_n, b_dq_oe;
  logic [7:0]  b_rd_data;
  logic [3:0]  b_dq_out;
  logic [3:0]  b_dq_in = 4'hF;

  qspi_mgmt_host #(.CLK_DIV(4), .DUMMY_CYCLES(DUMMY), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .qspi_sck(sck), .qspi_cs_n(cs_n), .qspi_dq_out(dq_out), .qspi_dq_oe(dq_oe),
    .qspi_dq_in(dq_in)
  );

  qspi_mgmt_host #(.CLK_DIV(2), .DUMMY_CYCLES(DUMMY), .CS_GAP(CS_GAP)) dut2 (
    .clk(clk), .rst_n(rst_n), .rd_en(b_rd_en), .wr_en(b_wr_en), .addr(b_addr),
    .wr_data(b_wr_data), .busy(b_busy), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .qspi_sck(b_sck), .qspi_cs_n(b_cs_n), .qspi_dq_out(b_dq_out), .qspi_dq_oe(b_dq_oe),
    .qspi_dq_in(b_dq_in)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rx;
    logic [7:0]  exp_op;
    logic        exp_rv;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic [4:0] exp_nib[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_model = 8'h00;
  logic [7:0] last_rd  = 8'h00;

  // monitor state for the CLK_DIV=4 instance
  int   rise_n = 0, last_rises = 0, cs_low_n = 0, cs_low_last = 0;
  int   cs_high_n = 0, cs_high_last = 0, sck_bad = 0, rv_cnt = 0;
  logic sck_prev = 1'b0, cs_prev = 1'b1;
  logic [4:0] e;

  // monitor state for the CLK_DIV=2 instance
  int   cyc = 0, b_rises = 0, b_last_rise = -1, b_period = 0, b_rv = 0;
  logic b_sck_prev = 1'b0;
  logic [7:0] b_rdata = 8'h00;
  logic [3:0] b_nibs[6];

  always @(negedge clk) begin
    cyc++;
    if (!cs_n) begin
      if (cs_prev) begin
        cs_high_last = cs_high_n;
        cs_low_n     = 0;
        rise_n       = 0;
      end
      cs_low_n++;
      if (sck && !sck_prev) begin
        rise_n++;
        if (exp_nib.size() == 0) check("extra_sck_rise", 1, 0);
        else begin
          e = exp_nib.pop_front();
          check("dq_oe_at_rise", dq_oe, e[4]);
          if (e[4]) check("dq_nibble", dq_out, e[3:0]);
        end
      end
    end else begin
      if (!cs_prev) begin
        cs_low_last = cs_low_n;
        last_rises  = rise_n;
        cs_high_n   = 0;
      end
      cs_high_n++;
      if (sck) sck_bad++;
    end
    if (rd_valid) begin
      rv_cnt++;
      if (exp_rd.size() == 0) check("spurious_rd_valid", 1, 0);
      else check("rd_data", rd_data, exp_rd.pop_front());
    end
    if (!cs_n && rise_n == 6 + DUMMY)      dq_in = rd_model[7:4];
    else if (!cs_n && rise_n == 7 + DUMMY) dq_in = rd_model[3:0];
    else                                   dq_in = 4'h0;
    sck_prev = sck;
    cs_prev  = cs_n;

    if (!b_cs_n && b_sck && !b_sck_prev) begin
      if (b_rises < 6) b_nibs[b_rises] = b_dq_out;
      b_rises++;
      if (b_last_rise >= 0) b_period = cyc - b_last_rise;
      b_last_rise = cyc;
    end
    if (b_rd_valid) begin
      b_rv++;
      b_rdata = b_rd_data;
    end
    b_sck_prev = b_sck;
  end

  task automatic start_txn(input vec_t v);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
    rd_en    = v.rd;
    wr_en    = v.wr;
    addr     = v.addr;
    wr_data  = v.wdata;
    rd_model = v.rx;
    exp_nib.push_back({1'b1, v.exp_op[7:4]});
    exp_nib.push_back({1'b1, v.exp_op[3:0]});
    for (int i = 3; i >= 0; i--) exp_nib.push_back({1'b1, v.addr[4*i +: 4]});
    if (v.exp_op == 8'h02) begin
      exp_nib.push_back({1'b1, v.wdata[7:4]});
      exp_nib.push_back({1'b1, v.wdata[3:0]});
    end else begin
      for (int i = 0; i < DUMMY + 2; i++) exp_nib.push_back(5'h00);
    end
    if (v.exp_rv) exp_rd.push_back(v.exp_rdata);
    rv_cnt = 0;
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_cs_n", cs_n, 0);
  endtask

  task automatic finish_txn(input vec_t v, input bit inject, input bit chk_gap);
    int n = 0;
    bit gap_hit = 1'b0;
    while (busy && n < 1000) begin
      if (inject && (n == 5 || (cs_n && !gap_hit))) begin
        wr_en   = 1'b1;
        addr    = 16'hDEAD;
        wr_data = 8'hEE;
      end else wr_en = 1'b0;
      if (cs_n) gap_hit = 1'b1;
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0;
    check("done_timeout", busy, 0);
    check("sck_count", last_rises, (v.exp_op == 8'h02) ? 8 : 8 + DUMMY);
    check("nibbles_left", exp_nib.size(), 0);
    check("rd_valid_count", rv_cnt, {31'd0, v.exp_rv});
    if (v.exp_rv) last_rd = v.exp_rdata;
    check("rd_data_hold", rd_data, last_rd);
    if (v.exp_op == 8'h02) check("cs_low_32pm2", (cs_low_last >= 30 && cs_low_last <= 34), 1);
    if (chk_gap) check("cs_high_ge_gap", cs_high_last >= CS_GAP, 1);
  endtask

  vec_t vecs[5];
  vec_t bb, rb, ab, ab2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00, 8'h02, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 8'h0B, 1'b1, 8'h3C};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 8'h55, 8'h99, 8'h02, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 16'hBEEF, 8'h00, 8'hC3, 8'h0B, 1'b1, 8'hC3};
    vecs[4] = '{1'b0, 1'b1, 16'h8001, 8'h0F, 8'h00, 8'h02, 1'b0, 8'h00};
    bb      = '{1'b0, 1'b1, 16'h5A5A, 8'h3C, 8'h00, 8'h02, 1'b0, 8'h00};
    rb      = '{1'b1, 1'b0, 16'h0F0F, 8'h00, 8'h5E, 8'h0B, 1'b1, 8'h5E};
    ab      = '{1'b1, 1'b0, 16'h4242, 8'h00, 8'h77, 8'h0B, 1'b1, 8'h77};
    ab2     = '{1'b1, 1'b0, 16'h4242, 8'h00, 8'h81, 8'h0B, 1'b1, 8'h81};

    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    b_rd_en = 1'b0; b_wr_en = 1'b0; b_addr = '0; b_wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // first request lands in the very cycle reset is released
    for (int i = 0; i < 5; i++) begin
      start_txn(vecs[i]);
      finish_txn(vecs[i], 1'b0, i != 0);
    end

    // requests during the frame and during the gap are dropped; next one is back-to-back
    start_txn(bb);
    finish_txn(bb, 1'b1, 1'b1);
    start_txn(rb);
    finish_txn(rb, 1'b0, 1'b1);

    // reset in the middle of the dummy phase
    start_txn(ab);
    begin
      int n = 0;
      while (rise_n < 7 && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    check("reach_dummy", rise_n >= 7, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_sck", sck, 0);
    check("abort_dq_oe", dq_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_data", rd_data, 0);
    exp_nib.delete();
    exp_rd.delete();
    last_rd = 8'h00;
    rst_n = 1'b1;
    start_txn(ab2);
    finish_txn(ab2, 1'b0, 1'b0);

    // CLK_DIV=2 read of 0xFFFF, the model holds every DQ line high
    @(negedge clk);
    b_addr  = 16'hFFFF;
    b_rd_en = 1'b1;
    @(negedge clk);
    b_rd_en = 1'b0;
    check("div2_accept_busy", b_busy, 1);
    begin
      int n = 0;
      while (b_busy && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    check("div2_done_timeout", b_busy, 0);
    check("div2_sck_count", b_rises, 12);
    check("div2_sck_period", b_period, 2);
    check("div2_rd_valid_count", b_rv, 1);
    check("div2_rd_data", b_rdata, 8'hFF);
    check("div2_rd_data_hold", b_rd_data, 8'hFF);
    begin
      logic [23:0] hdr;
      hdr = {8'h0B, 16'hFFFF};
      for (int i = 0; i < 6; i++) check("div2_header_nibble", b_nibs[i], hdr[23 - 4*i -: 4]);
    end

    check("sck_toggle_with_cs_high", sck_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
